// File: rtl/alu_sequencer_if.sv
// Command/response bus between an upstream controller and the ALU sequencer.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high; once valid is raised its payload holds until that edge.
interface alu_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [DATA_W-1:0] cmd_c;
    logic [1:0]        cmd_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [OUT_W-1:0]  rsp_data;
    logic [1:0]        rsp_sel;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_c, cmd_sel, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_sel
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_c, cmd_sel, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_sel
    );
endinterface

// File: rtl/alu_sequencer.sv
// Registered front-end for a combinational 3-operand ALU: takes one command,
// drives the ALU inputs, waits SETTLE_CYCLES edges, then returns the captured result.
module alu_sequencer #(
    parameter int DATA_W        = 8,
    parameter int OUT_W         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_sequencer_if.slave    bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_c,
    output logic              alu_s0,
    output logic              alu_s1,
    input  logic [OUT_W-1:0]  alu_out,
    output logic              busy,
    output logic [7:0]        op_count,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;

    assign bus.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_c         <= '0;
            alu_s0        <= 1'b0;
            alu_s1        <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_sel   <= 2'b00;
            op_count      <= 8'd0;
        end else if (flush) begin
            // Abort wins over every transition; ALU drive and op_count are left alone.
            state         <= IDLE;
            cnt           <= 4'd0;
            bus.rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        alu_a       <= bus.cmd_a;
                        alu_b       <= bus.cmd_b;
                        alu_c       <= bus.cmd_c;
                        alu_s0      <= bus.cmd_sel[0];
                        alu_s1      <= bus.cmd_sel[1];
                        bus.rsp_sel <= bus.cmd_sel;
                        cnt         <= CNT_INIT;
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Counter reaching zero marks edge accept+SETTLE_CYCLES.
                    if (cnt == 4'd0) begin
                        bus.rsp_data  <= alu_out;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        op_count      <= op_count + 8'd1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an ALU stub returning {alu_b, alu_a}.
module tb_alu_sequencer;

    localparam logic [1:0] ST_IDLE = 2'd0;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_c;
    logic        alu_s0;
    logic        alu_s1;
    logic [15:0] alu_out;
    logic        busy;
    logic [7:0]  op_count;
    logic [1:0]  dbg_state;
    logic        glitch;

    int          n_cmp;
    int          n_err;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    alu_sequencer_if #(.DATA_W(8), .OUT_W(16)) sif ();

    alu_sequencer #(.DATA_W(8), .OUT_W(16), .SETTLE_CYCLES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(sif),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_c(alu_c),
        .alu_s0(alu_s0),
        .alu_s1(alu_s1),
        .alu_out(alu_out),
        .busy(busy),
        .op_count(op_count),
        .dbg_state(dbg_state)
    );

    // ALU stub; glitch forces a bogus value to show when OUT is really sampled
    assign alu_out = glitch ? 16'hDEAD : {alu_b, alu_a};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [1:0] sel);
        sif.cmd_a     = a;
        sif.cmd_b     = b;
        sif.cmd_c     = c;
        sif.cmd_sel   = sel;
        sif.cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (sif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", sif.cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (sif.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", sif.rsp_valid); end
        n_cmp++; if ({alu_a, alu_b, alu_c, alu_s0, alu_s1} !== 26'd0) begin n_err++; $display("FAIL reset_alu_regs: got %h %h %h %b %b want all 0", alu_a, alu_b, alu_c, alu_s0, alu_s1); end
        n_cmp++; if ({sif.rsp_data, sif.rsp_sel, op_count} !== 26'd0) begin n_err++; $display("FAIL reset_rsp_regs: got %h %b %0d want all 0", sif.rsp_data, sif.rsp_sel, op_count); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive_cmd(8'd100, 8'd20, 8'd34, 2'b00);
        tick();
        sif.cmd_valid = 1'b0;
        n_cmp++; if ({alu_a, alu_b, alu_c} !== {8'd100, 8'd20, 8'd34}) begin n_err++; $display("FAIL basic_alu_abc: got %0d %0d %0d want 100 20 34", alu_a, alu_b, alu_c); end
        n_cmp++; if ({alu_s1, alu_s0} !== 2'b00) begin n_err++; $display("FAIL basic_alu_sel: got %b%b want 00", alu_s1, alu_s0); end
        n_cmp++; if (sif.cmd_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got ready=%b busy=%b want 0 1", sif.cmd_ready, busy); end
        tick();
        n_cmp++; if (sif.rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_rsp_early: got %b want 0", sif.rsp_valid); end
        tick();
        n_cmp++; if (sif.rsp_valid !== 1'b1) begin n_err++; $display("FAIL basic_rsp_valid: got %b want 1", sif.rsp_valid); end
        n_cmp++; if (sif.rsp_data !== 16'h1464) begin n_err++; $display("FAIL basic_rsp_data: got %h want 1464", sif.rsp_data); end
        n_cmp++; if (sif.rsp_sel !== 2'b00) begin n_err++; $display("FAIL basic_rsp_sel: got %b want 00", sif.rsp_sel); end
        sif.rsp_ready = 1'b1;
        tick();
        sif.rsp_ready = 1'b0;
        n_cmp++; if (sif.rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_rsp_drop: got %b want 0", sif.rsp_valid); end
        n_cmp++; if (op_count !== 8'd1) begin n_err++; $display("FAIL basic_op_count: got %0d want 1", op_count); end
        n_cmp++; if (sif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_back: got %b want 1", sif.cmd_ready); end
    endtask

    task automatic test_back_to_back();
        sif.rsp_ready = 1'b0;
        drive_cmd(8'd15, 8'd34, 8'd0, 2'b01);
        tick();
        // second command offered at once and held pending
        drive_cmd(8'd25, 8'd2, 8'd7, 2'b10);
        tick();
        tick();
        n_cmp++; if (sif.rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid: got %b want 1", sif.rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (sif.rsp_valid !== 1'b1 || sif.rsp_data !== 16'h220F || sif.rsp_sel !== 2'b01) begin n_err++; $display("FAIL b2b_hold_%0d: got v=%b d=%h s=%b want 1 220f 01", i, sif.rsp_valid, sif.rsp_data, sif.rsp_sel); end
            n_cmp++; if (sif.cmd_ready !== 1'b0 || alu_a !== 8'd15) begin n_err++; $display("FAIL b2b_blocked_%0d: got ready=%b alu_a=%0d want 0 15", i, sif.cmd_ready, alu_a); end
        end
        sif.rsp_ready = 1'b1;
        tick();
        n_cmp++; if (op_count !== 8'd2 || sif.rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_first_hs: got cnt=%0d v=%b want 2 0", op_count, sif.rsp_valid); end
        n_cmp++; if (sif.cmd_ready !== 1'b1 || alu_a !== 8'd15) begin n_err++; $display("FAIL b2b_not_yet: got ready=%b alu_a=%0d want 1 15", sif.cmd_ready, alu_a); end
        tick();
        sif.cmd_valid = 1'b0;
        n_cmp++; if (alu_a !== 8'd25 || alu_b !== 8'd2 || {alu_s1, alu_s0} !== 2'b10) begin n_err++; $display("FAIL b2b_second_acc: got a=%0d b=%0d s=%b%b want 25 2 10", alu_a, alu_b, alu_s1, alu_s0); end
        tick();
        tick();
        n_cmp++; if (sif.rsp_valid !== 1'b1 || sif.rsp_data !== 16'h0219 || sif.rsp_sel !== 2'b10) begin n_err++; $display("FAIL b2b_second_rsp: got v=%b d=%h s=%b want 1 0219 10", sif.rsp_valid, sif.rsp_data, sif.rsp_sel); end
        tick();
        sif.rsp_ready = 1'b0;
        n_cmp++; if (op_count !== 8'd3) begin n_err++; $display("FAIL b2b_op_count: got %0d want 3", op_count); end
    endtask

    task automatic test_settle_glitch();
        drive_cmd(8'h5A, 8'hA5, 8'h00, 2'b00);
        tick();
        sif.cmd_valid = 1'b0;
        glitch = 1'b1;
        tick();
        n_cmp++; if (sif.rsp_valid !== 1'b0) begin n_err++; $display("FAIL glitch_early_valid: got %b want 0", sif.rsp_valid); end
        @(negedge clk);
        glitch = 1'b0;
        tick();
        n_cmp++; if (sif.rsp_valid !== 1'b1 || sif.rsp_data !== 16'hA55A) begin n_err++; $display("FAIL glitch_sample: got v=%b d=%h want 1 a55a", sif.rsp_valid, sif.rsp_data); end
        sif.rsp_ready = 1'b1;
        tick();
        sif.rsp_ready = 1'b0;
        n_cmp++; if (op_count !== 8'd4) begin n_err++; $display("FAIL glitch_op_count: got %0d want 4", op_count); end
    endtask

    task automatic test_flush();
        // flush while settling
        drive_cmd(8'd1, 8'd255, 8'd128, 2'b11);
        tick();
        sif.cmd_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (sif.rsp_valid !== 1'b0 || dbg_state !== ST_IDLE || busy !== 1'b0) begin n_err++; $display("FAIL flush_settle: got v=%b st=%0d busy=%b want 0 0 0", sif.rsp_valid, dbg_state, busy); end
        n_cmp++; if (op_count !== 8'd4 || alu_a !== 8'd1 || alu_c !== 8'd128) begin n_err++; $display("FAIL flush_settle_keep: got cnt=%0d a=%0d c=%0d want 4 1 128", op_count, alu_a, alu_c); end
        tick();
        tick();
        n_cmp++; if (sif.rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_stray: got %b want 0", sif.rsp_valid); end
        // flush while holding a response
        drive_cmd(8'd1, 8'd255, 8'd128, 2'b11);
        tick();
        sif.cmd_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (sif.rsp_valid !== 1'b1) begin n_err++; $display("FAIL flush_resp_pre: got %b want 1", sif.rsp_valid); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (sif.rsp_valid !== 1'b0 || dbg_state !== ST_IDLE || op_count !== 8'd4) begin n_err++; $display("FAIL flush_resp: got v=%b st=%0d cnt=%0d want 0 0 4", sif.rsp_valid, dbg_state, op_count); end
        // flush beats a command offered in IDLE
        drive_cmd(8'd1, 8'd255, 8'd128, 2'b11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL flush_idle_cmd: got busy=%b st=%0d want 0 0", busy, dbg_state); end
        tick();
        sif.cmd_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || {alu_s1, alu_s0} !== 2'b11) begin n_err++; $display("FAIL flush_after_acc: got busy=%b s=%b%b want 1 11", busy, alu_s1, alu_s0); end
        tick();
        tick();
        n_cmp++; if (sif.rsp_valid !== 1'b1 || sif.rsp_data !== 16'hFF01 || sif.rsp_sel !== 2'b11) begin n_err++; $display("FAIL flush_after_rsp: got v=%b d=%h s=%b want 1 ff01 11", sif.rsp_valid, sif.rsp_data, sif.rsp_sel); end
        sif.rsp_ready = 1'b1;
        tick();
        sif.rsp_ready = 1'b0;
        n_cmp++; if (op_count !== 8'd5) begin n_err++; $display("FAIL flush_op_count: got %0d want 5", op_count); end
    endtask

    task automatic test_wrap();
        // 250 ops at the minimum 4-edge period take op_count from 5 to 255
        sif.rsp_ready = 1'b1;
        for (int i = 0; i < 251; i++) begin
            drive_cmd(8'(i), 8'(255 - i), 8'(i + 3), 2'(i));
            exp_q.push_back({8'(255 - i), 8'(i)});
            tick();
            sif.cmd_valid = 1'b0;
            tick();
            tick();
            exp_v = exp_q.pop_front();
            n_cmp++; if (sif.rsp_valid !== 1'b1 || sif.rsp_data !== exp_v) begin n_err++; $display("FAIL wrap_rsp_%0d: got v=%b d=%h want 1 %h", i, sif.rsp_valid, sif.rsp_data, exp_v); end
            tick();
            if (i == 249) begin
                n_cmp++; if (op_count !== 8'd255) begin n_err++; $display("FAIL wrap_at_255: got %0d want 255", op_count); end
            end
        end
        sif.rsp_ready = 1'b0;
        n_cmp++; if (op_count !== 8'd0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL wrap_to_0: got cnt=%0d st=%0d want 0 0", op_count, dbg_state); end
    endtask

    task automatic test_async_reset();
        sif.rsp_ready = 1'b1;
        drive_cmd(8'd9, 8'd8, 8'd7, 2'b01);
        tick();
        sif.cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        sif.rsp_ready = 1'b0;
        n_cmp++; if (op_count !== 8'd1 || alu_a !== 8'd9) begin n_err++; $display("FAIL arst_pre: got cnt=%0d a=%0d want 1 9", op_count, alu_a); end
        drive_cmd(8'd40, 8'd50, 8'd60, 2'b10);
        tick();
        sif.cmd_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({alu_a, alu_b, alu_c, alu_s0, alu_s1} !== 26'd0) begin n_err++; $display("FAIL arst_alu_regs: got %h %h %h %b %b want all 0", alu_a, alu_b, alu_c, alu_s0, alu_s1); end
        n_cmp++; if ({sif.rsp_data, sif.rsp_sel, op_count} !== 26'd0 || sif.rsp_valid !== 1'b0) begin n_err++; $display("FAIL arst_rsp_regs: got d=%h s=%b cnt=%0d v=%b want 0", sif.rsp_data, sif.rsp_sel, op_count, sif.rsp_valid); end
        n_cmp++; if (sif.cmd_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL arst_ready: got ready=%b busy=%b want 1 0", sif.cmd_ready, busy); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        sif.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        sif.rsp_ready = 1'b0;
        n_cmp++; if (sif.rsp_valid !== 1'b0 || op_count !== 8'd0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL arst_no_rsp: got v=%b cnt=%0d st=%0d want 0 0 0", sif.rsp_valid, op_count, dbg_state); end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        glitch        = 1'b0;
        sif.cmd_valid = 1'b0;
        sif.cmd_a     = 8'd0;
        sif.cmd_b     = 8'd0;
        sif.cmd_c     = 8'd0;
        sif.cmd_sel   = 2'b00;
        sif.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_settle_glitch();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Clocked front-end that feeds operands to the combinational 3-operand ALU (A, B, C 8-bit; S0/S1 select; 16-bit OUT) and reads back its result.
- Accepts one operation per command handshake and drives the ALU inputs from registers.
- Waits a fixed settle time, then captures OUT and presents it on a response handshake.
- Replaces hand-timed stimulus with a hardware initiator/reader, so ALU operations can be issued by any upstream controller.

Parameters:
- DATA_W, 8, width of each ALU operand and of cmd_a/cmd_b/cmd_c.
- OUT_W, 16, width of the ALU result and of rsp_data.
- SETTLE_CYCLES, 2, clock edges between driving the ALU inputs and sampling OUT. Legal range 1..15; 0 is illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of any in-flight operation.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_a  input  DATA_W  operand A.
- cmd_b  input  DATA_W  operand B.
- cmd_c  input  DATA_W  operand C.
- cmd_sel  input  2  operation select; bit1 maps to S1, bit0 maps to S0.
- alu_a  output  DATA_W  registered drive to ALU A.
- alu_b  output  DATA_W  registered drive to ALU B.
- alu_c  output  DATA_W  registered drive to ALU C.
- alu_s0  output  1  registered drive to ALU S0.
- alu_s1  output  1  registered drive to ALU S1.
- alu_out  input  OUT_W  ALU result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  OUT_W  captured ALU result.
- rsp_sel  output  2  select value that produced rsp_data.
- busy  output  1  high in any state other than IDLE.
- op_count  output  8  count of completed responses.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - alu_a/b/c, alu_s0/s1, rsp_data, rsp_sel, op_count, settle counter all 0.
  - rsp_valid 0, busy 0.
  - cmd_ready reads 1 (it is decoded from state == IDLE).
- States: IDLE, SETTLE, RESP. Only these three are reachable; any other encoding recovers to IDLE on the next edge.
- IDLE:
  - cmd_ready = 1.
  - On an edge with cmd_valid & cmd_ready: load alu_* from cmd_*, load rsp_sel <= cmd_sel, load counter <= SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - cmd_ready = 0.
  - Counter decrements each edge.
  - On the edge where the counter is 0: rsp_data <= alu_out, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_sel are held stable until rsp_ready is sampled high.
  - On that edge: rsp_valid <= 0, op_count <= op_count+1 (wraps 255 -> 0), go to IDLE.
- Latency:
  - Command accepted at edge k; ALU inputs change at edge k.
  - alu_out is sampled at edge k+SETTLE_CYCLES; rsp_valid is high from edge k+SETTLE_CYCLES.
  - With rsp_ready held high, the minimum command-to-command period is SETTLE_CYCLES+2 edges.
- alu_* outputs keep their last values after an operation completes. They are not cleared in IDLE, only by reset.
- rsp_ready is ignored outside RESP. cmd_valid is ignored outside IDLE; the offered command stays pending upstream.
- flush (priority over all transitions except reset):
  - Next state IDLE, rsp_valid <= 0, counter <= 0.
  - op_count and the alu_* registers are unchanged.
  - A flush in RESP discards the result without incrementing op_count.
  - flush together with cmd_valid in IDLE: the command is NOT accepted.
- Reset asserted mid-operation: immediate return to the reset values above; the operation is lost.
- busy = (state != IDLE).

Test Plan (bench ALU stub drives alu_out = {alu_b, alu_a}):
- Reset release, SETTLE_CYCLES=2, send A=100, B=20, C=34, sel=00 -> alu_a=100, alu_b=20, alu_c=34 one edge after accept; rsp_valid rises 2 edges after accept with rsp_data=16'h1464, rsp_sel=00; op_count=1 after rsp handshake.
- Back-to-back with rsp_ready low for 5 cycles: A=15, B=34, sel=01, then A=25, B=2, sel=10 -> first rsp_data=16'h220F held stable all 5 cycles; cmd_ready=0 throughout; second command accepted only after the response handshake, then rsp_data=16'h0219.
- alu_out changes at settle edge-1 vs settle edge: stub glitches alu_out to 16'hDEAD until the sample edge -> rsp_data equals the value present at edge k+SETTLE_CYCLES only.
- flush in SETTLE and flush in RESP (A=1, B=255, C=128, sel=11) -> rsp_valid=0 next edge, state IDLE, op_count unchanged; a later command completes normally with rsp_data=16'hFF01.
- 256 completed operations -> op_count wraps to 0.
- rst_n pulsed low mid-SETTLE between edges -> all outputs zero immediately, cmd_ready=1, no response produced.
